k503_scan: RTL

Clocked, parametrised successor to the Konami 503 sprite line selector. Walks the sprite attribute RAM once per scanline. For each slot it fetches the Y and attribute bytes, tests vertical hit against `VCNT`, and enforces a per-line sprite limit. For each visible slot it generates the line-buffer chip select, flip, row/column address and the ODAT/OCOL strobes. Sits between sprite RAM and the sprite ROM/line-buffer address logic; runs on the system clock with a pixel clock enable.

---
 rtl/k503_scan_pkg.sv | 22 ++
 rtl/k503_hit_check.sv | 22 ++
 rtl/k503_scan.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/k503_scan_pkg.sv
// Shared types and constants for the k503 sprite line selector.
package k503_scan_pkg;

    // Scan states; each active slot walks FETCH_Y -> FETCH_ATTR -> DRAW.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH_Y,
        ST_FETCH_ATTR,
        ST_DRAW
    } state_e;

    // Phase points inside the 16-tick slot.
    localparam logic [3:0] PH_Y_SAMPLE = 4'd3;
    localparam logic [3:0] PH_COMMIT   = 4'd7;
    localparam logic [3:0] PH_ODAT     = 4'd11;
    localparam logic [3:0] PH_OCOL     = 4'd15;

    // Low bit of the sprite RAM address: which byte of the record is read.
    localparam logic BYTE_SEL_Y    = 1'b0;
    localparam logic BYTE_SEL_ATTR = 1'b1;

endpackage

// File: rtl/k503_hit_check.sv
// Vertical hit test: Y + VCNT wraps; the sprite covers this line when the
// bits above the in-sprite row are all ones.
module k503_hit_check #(
    parameter int VW        = 8,
    parameter int SIZE_LOG2 = 4
) (
    input  logic [VW-1:0]        y_byte,
    input  logic [VW-1:0]        vcnt,
    output logic                 hit,
    output logic [SIZE_LOG2-1:0] row
);

    logic [VW-1:0] sum;

    // Modular add and all-ones compare of the upper bits.
    always_comb begin
        sum = y_byte + vcnt;
        hit = &sum[VW-1:SIZE_LOG2];
        row = sum[SIZE_LOG2-1:0];
    end

endmodule

// File: rtl/k503_scan.sv
// Sprite line selector: walks sprite attribute RAM once per scanline,
// picks up to MAX_HITS visible sprites and drives line-buffer controls.
module k503_scan
    import k503_scan_pkg::*;
#(
    parameter int VW        = 8,
    parameter int SIZE_LOG2 = 4,
    parameter int NUM_SLOTS = 24,
    parameter int MAX_HITS  = 8
) (
    input  logic                           CLK,
    input  logic                           RESETn,
    input  logic                           CEN,
    input  logic                           LINE_START,
    input  logic [VW-1:0]                  VCNT,
    input  logic                           FLIP_SCREEN,
    input  logic [7:0]                     OB,
    output logic [$clog2(NUM_SLOTS):0]     OB_ADDR,
    output logic                           OCS,
    output logic                           OFLP,
    output logic                           ODAT,
    output logic                           OCOL,
    output logic [SIZE_LOG2+1:0]           R,
    output logic [$clog2(MAX_HITS+1)-1:0]  HIT_CNT,
    output logic                           OVERFLOW,
    output logic                           SCAN_DONE
);

    localparam int SW = $clog2(NUM_SLOTS);
    localparam int HW = $clog2(MAX_HITS + 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SLOTS - 1);
    localparam logic [HW-1:0] HIT_MAX   = HW'(MAX_HITS);

    state_e                 state_q, state_d;
    logic [3:0]             ph_q, ph_d;
    logic [SW-1:0]          slot_q, slot_d;
    logic                   hit_pend_q, hit_pend_d;
    logic [SIZE_LOG2-1:0]   row_pend_q, row_pend_d;
    logic                   act_q, act_d;
    logic                   hflip_q, hflip_d;
    logic [SIZE_LOG2-1:0]   row_out_q, row_out_d;
    logic [HW-1:0]          hit_cnt_q, hit_cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;

    logic                   y_hit;
    logic [SIZE_LOG2-1:0]   y_row;
    logic                   vflip;
    logic                   idle;
    logic                   byte_sel;

    k503_hit_check #(
        .VW        (VW),
        .SIZE_LOG2 (SIZE_LOG2)
    ) u_hit_check (
        .y_byte (OB),
        .vcnt   (VCNT),
        .hit    (y_hit),
        .row    (y_row)
    );

    // Next-state: phase/slot sequencing, Y sample, commit and line restart.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        ph_d       = ph_q;
        slot_d     = slot_q;
        hit_pend_d = hit_pend_q;
        row_pend_d = row_pend_q;
        act_d      = act_q;
        hflip_d    = hflip_q;
        row_out_d  = row_out_q;
        hit_cnt_d  = hit_cnt_q;
        ovf_d      = ovf_q;
        done_d     = done_q;
        vflip      = 1'b0;

        if (CEN) begin
            if (LINE_START) begin
                state_d    = ST_FETCH_Y;
                ph_d       = 4'd0;
                slot_d     = '0;
                hit_pend_d = 1'b0;
                row_pend_d = '0;
                act_d      = 1'b0;
                hflip_d    = 1'b0;
                row_out_d  = '0;
                hit_cnt_d  = '0;
                ovf_d      = 1'b0;
                done_d     = 1'b0;
            end else if (state_q != ST_IDLE) begin
                ph_d = ph_q + 4'd1;

                if (ph_q == PH_Y_SAMPLE) begin
                    hit_pend_d = y_hit;
                    row_pend_d = y_row;
                end

                if (ph_q == PH_COMMIT) begin
                    vflip     = OB[7] ^ FLIP_SCREEN;
                    hflip_d   = OB[6] ^ FLIP_SCREEN;
                    row_out_d = row_pend_q ^ {SIZE_LOG2{vflip}};
                    act_d     = 1'b0;
                    if (hit_pend_q) begin
                        if (hit_cnt_q < HIT_MAX) begin
                            act_d     = 1'b1;
                            hit_cnt_d = hit_cnt_q + HW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end

                case (ph_d[3:2])
                    2'd0:    state_d = ST_FETCH_Y;
                    2'd1:    state_d = ST_FETCH_ATTR;
                    default: state_d = ST_DRAW;
                endcase

                if (ph_q == PH_OCOL) begin
                    if (slot_q == LAST_SLOT) begin
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                        act_d     = 1'b0;
                        hflip_d   = 1'b0;
                        row_out_d = '0;
                    end else begin
                        slot_d = slot_q + SW'(1);
                    end
                end
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            ph_q       <= 4'd0;
            slot_q     <= '0;
            hit_pend_q <= 1'b0;
            row_pend_q <= '0;
            act_q      <= 1'b0;
            hflip_q    <= 1'b0;
            row_out_q  <= '0;
            hit_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q    <= state_d;
            ph_q       <= ph_d;
            slot_q     <= slot_d;
            hit_pend_q <= hit_pend_d;
            row_pend_q <= row_pend_d;
            act_q      <= act_d;
            hflip_q    <= hflip_d;
            row_out_q  <= row_out_d;
            hit_cnt_q  <= hit_cnt_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    // Outputs decoded directly from registered state; strobes only for active slots.
    always_comb begin
        idle      = (state_q == ST_IDLE);
        byte_sel  = (state_q == ST_FETCH_ATTR) ? BYTE_SEL_ATTR : BYTE_SEL_Y;
        OB_ADDR   = idle ? '0 : {slot_q, byte_sel};
        OCS       = ~act_q;
        OFLP      = hflip_q;
        R         = idle ? '0 : {row_out_q, hflip_q ^ ph_q[3], hflip_q ^ ~ph_q[2]};
        ODAT      = ~(act_q && (state_q == ST_DRAW) && (ph_q == PH_ODAT));
        OCOL      = ~(act_q && (state_q == ST_DRAW) && (ph_q == PH_OCOL));
        HIT_CNT   = hit_cnt_q;
        OVERFLOW  = ovf_q;
        SCAN_DONE = done_q;
    end

endmodule
